ahb_sram_slave: RTL and testbench

AHB5 slave memory that terminates the master-side AHB port of the pass-through template stage and acts as its downstream consumer. It decodes single and burst transfers into a word-organised register array, inserts a configurable number of wait states, and signals ERROR for illegal accesses. It also carries a single-entry exclusive-access monitor that drives `hexokay`.

---
 rtl/ahb_pkg.sv | 69 ++++++
 rtl/ahb_excl_monitor.sv | 55 +++++
 rtl/ahb_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB5 types, encodings and small decode helpers for the SRAM slave slice.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: transfer/burst/size encodings, response codes, the slave data-phase
// state encoding, and helpers for alignment checking and byte-lane generation.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // no data phase pending
        ST_WAIT = 3'd1,   // inserting wait states
        ST_DATA = 3'd2,   // final data-phase cycle, hready high
        ST_ERR1 = 3'd3,   // first error cycle, hready low
        ST_ERR2 = 3'd4    // second error cycle, hready high
    } slv_state_t;

    // True when the byte address low bits are naturally aligned to the size.
    function automatic logic align_ok(input logic [2:0] lo, input logic [2:0] size);
        logic ok;
        case (size)
            HSIZE_BYTE:  ok = 1'b1;
            HSIZE_HALF:  ok = (lo[0] == 1'b0);
            HSIZE_WORD:  ok = (lo[1:0] == 2'b00);
            HSIZE_DWORD: ok = (lo == 3'b000);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables for a transfer of 'size' starting at lane 'lo' on a
    // bus up to 64 bits wide; narrower buses use the low lanes only.
    function automatic logic [7:0] byte_lanes(input logic [2:0] lo, input logic [2:0] size);
        logic [7:0] base;
        case (size)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        return base << lo;
    endfunction

endpackage

// File: rtl/ahb_excl_monitor.sv
// Single-entry exclusive-access reservation (valid, word index, master ID).
// Latency: pass/clear are combinational in the final data-phase cycle; the entry updates at that edge.
// Backpressure: none; evaluated only when the parent commits a data phase.
//
// Ports:
//   hclk, hresetn     clock and synchronous active-low reset
//   commit            parent is in its final OKAY data-phase cycle
//   wr, excl          committing transfer is a write / is exclusive
//   idx, master       word index and master ID of the committing transfer
//   excl_pass         exclusive write matches the reservation (perform it, hexokay)
//   excl_clear        reservation is dropped at this edge
module ahb_excl_monitor #(
    parameter int IDX_BITS = 10
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                commit,
    input  logic                wr,
    input  logic                excl,
    input  logic [IDX_BITS-1:0] idx,
    input  logic [3:0]          master,
    output logic                excl_pass,
    output logic                excl_clear
);

    logic                res_vld;
    logic [IDX_BITS-1:0] res_idx;
    logic [3:0]          res_master;

    logic idx_hit;
    logic set_res;

    assign idx_hit   = res_vld && (idx == res_idx);
    assign excl_pass = commit && wr && excl && idx_hit && (master == res_master);

    // A successful exclusive write consumes the reservation; any plain write
    // to the reserved word (from any master) breaks it.
    assign excl_clear = commit && wr && (excl ? excl_pass : idx_hit);
    assign set_res    = commit && !wr && excl;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            res_vld    <= 1'b0;
            res_idx    <= '0;
            res_master <= '0;
        end else if (set_res) begin
            res_vld    <= 1'b1;
            res_idx    <= idx;
            res_master <= master;
        end else if (excl_clear) begin
            res_vld    <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB5 slave backed by a word-organised register array with wait states, ERROR on illegal access and an exclusive monitor.
// Latency: data phase is WAIT_STATES+1 cycles for legal transfers, exactly 2 cycles for ERROR; zero-wait pipelines at 1/cycle.
// Backpressure: hready low during wait states and the first error cycle; address-phase inputs are not sampled then.
//
// Ports:
//   hclk, hresetn                 clock, synchronous active-low reset
//   hsel, haddr, htrans, hsize,   address phase (captured on accept)
//   hwrite, hexcl, hmaster
//   hburst, hmastlock, hprot,     accepted but unused: each beat is decoded alone
//   hnonsec
//   hwdata                        write data, sampled at the edge ending the data phase
//   hrdata, hready, hresp,        data-phase response
//   hexokay
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hburst,
    input  logic                  hmastlock,
    input  logic [6:0]            hprot,
    input  logic                  hnonsec,
    input  logic [2:0]            hsize,
    input  logic                  hexcl,
    input  logic [3:0]            hmaster,
    input  logic [1:0]            htrans,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hwrite,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp,
    output logic                  hexokay
);

    import ahb_pkg::*;

    localparam int                  BYTES     = DATA_WIDTH / 8;
    localparam int                  LANE_BITS = $clog2(BYTES);
    localparam int                  IDX_BITS  = $clog2(MEM_WORDS);
    localparam logic [2:0]          MAX_SIZE  = 3'(LANE_BITS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * BYTES);
    localparam logic [3:0]          WS        = 4'(WAIT_STATES);

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] off;
    logic [2:0]            lo;
    logic [7:0]            lanes;
    logic                  in_range;
    logic                  size_ok;
    logic                  aligned;
    logic                  legal;
    logic                  accept;

    always_comb begin
        off                = haddr - BASE_ADDR;
        lo                 = '0;
        lo[LANE_BITS-1:0]  = haddr[LANE_BITS-1:0];
        in_range           = (haddr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
        size_ok            = (hsize <= MAX_SIZE);
        aligned            = align_ok(lo, hsize);
        legal              = in_range && size_ok && aligned;
        lanes              = byte_lanes(lo, hsize);
    end

    assign accept = hsel && htrans[1] && hready;

    // ------------------------------------------------------------------
    // Data-phase state
    // ------------------------------------------------------------------
    slv_state_t          state;
    slv_state_t          state_nxt;
    logic [3:0]          wait_cnt;
    logic [3:0]          cnt_nxt;
    logic [IDX_BITS-1:0] d_idx;
    logic [7:0]          d_strb;
    logic                d_write;
    logic                d_excl;
    logic [3:0]          d_master;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all have hready high and may accept.
                if (accept) begin
                    if (!legal) begin
                        state_nxt = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            d_idx    <= '0;
            d_strb   <= '0;
            d_write  <= 1'b0;
            d_excl   <= 1'b0;
            d_master <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (accept) begin
                d_idx    <= off[LANE_BITS +: IDX_BITS];
                d_strb   <= lanes;
                d_write  <= hwrite;
                d_excl   <= hexcl;
                d_master <= hmaster;
            end
        end
    end

    // ------------------------------------------------------------------
    // Exclusive monitor
    // ------------------------------------------------------------------
    logic commit;
    logic excl_pass;
    logic excl_clear;

    assign commit = (state == ST_DATA);

    ahb_excl_monitor #(
        .IDX_BITS (IDX_BITS)
    ) u_excl_monitor (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .commit     (commit),
        .wr         (d_write),
        .excl       (d_excl),
        .idx        (d_idx),
        .master     (d_master),
        .excl_pass  (excl_pass),
        .excl_clear (excl_clear)
    );

    // ------------------------------------------------------------------
    // Array
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                  mem_we;

    // A failed exclusive write is suppressed; a reset at the commit edge
    // drops the pending write.
    assign mem_we = commit && d_write && (!d_excl || excl_pass) && hresetn;

    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_strb[b]) begin
                    mem[d_idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    assign hready  = !((state == ST_WAIT) || (state == ST_ERR1));
    assign hresp   = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata  = (commit && !d_write) ? mem[d_idx] : '0;
    assign hexokay = excl_pass;

    // Inputs carried for interface completeness but not needed for decode.
    logic unused_ok;
    assign unused_ok = ^{hburst, hmastlock, hprot, hnonsec, htrans[0], d_strb};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) driven by a pipelined AHB master against a transaction-level model.
// Latency: checks the data-phase length of every transfer against the configured wait states.
// Backpressure: the master holds address-phase signals while hready is low.
module tb_ahb_sram_slave;

    localparam int NDUT = 2;

    typedef struct {
        bit        gap;
        bit        gap_sel;
        bit [1:0]  trans;
        bit [31:0] addr;
        int        size;
        bit        wr;
        bit        excl;
        int        mst;
        bit [31:0] wdata;
    } xfer_t;

    logic        hclk;
    logic        hresetn [NDUT];
    logic        hsel    [NDUT];
    logic [31:0] haddr   [NDUT];
    logic [2:0]  hsize   [NDUT];
    logic        hexcl   [NDUT];
    logic [3:0]  hmaster [NDUT];
    logic [1:0]  htrans  [NDUT];
    logic [31:0] hwdata  [NDUT];
    logic        hwrite  [NDUT];
    logic [31:0] hrdata  [NDUT];
    logic        hready  [NDUT];
    logic        hresp   [NDUT];
    logic        hexokay [NDUT];
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [6:0]  hprot;
    logic        hnonsec;

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn[0]), .hsel(hsel[0]), .haddr(haddr[0]),
        .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .hnonsec(hnonsec),
        .hsize(hsize[0]), .hexcl(hexcl[0]), .hmaster(hmaster[0]), .htrans(htrans[0]),
        .hwdata(hwdata[0]), .hwrite(hwrite[0]), .hrdata(hrdata[0]), .hready(hready[0]),
        .hresp(hresp[0]), .hexokay(hexokay[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn[1]), .hsel(hsel[1]), .haddr(haddr[1]),
        .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .hnonsec(hnonsec),
        .hsize(hsize[1]), .hexcl(hexcl[1]), .hmaster(hmaster[1]), .htrans(htrans[1]),
        .hwdata(hwdata[1]), .hwrite(hwrite[1]), .hrdata(hrdata[1]), .hready(hready[1]),
        .hresp(hresp[1]), .hexokay(hexokay[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: memory window (words 0..63) and one reservation per slave.
    bit [31:0] mem_m [NDUT][64];
    bit        rv    [NDUT];
    int        ridx  [NDUT];
    int        rmst  [NDUT];

    xfer_t txq[$];
    int    n_checks;
    int    n_errors;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Legal: inside the 4 KiB array, at most word size, naturally aligned.
    function automatic bit is_legal(input xfer_t x);
        if (x.addr >= 32'd4096) return 1'b0;
        if (x.size > 2) return 1'b0;
        if ((x.addr % (32'd1 << x.size)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_x(input bit [31:0] addr, input int size, input bit wr,
                          input bit excl, input int mst, input bit [31:0] wdata);
        xfer_t x;
        x.gap = 1'b0; x.gap_sel = 1'b0;
        x.trans = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
        x.addr = addr; x.size = size; x.wr = wr; x.excl = excl; x.mst = mst; x.wdata = wdata;
        txq.push_back(x);
    endtask

    task automatic push_gap();
        xfer_t x;
        x.gap = 1'b1; x.gap_sel = 1'($urandom_range(0, 1));
        x.trans = 2'($urandom_range(0, 1));
        x.addr = $urandom; x.size = 2; x.wr = 1'($urandom_range(0, 1));
        x.excl = 1'b0; x.mst = 0; x.wdata = 32'h0;
        txq.push_back(x);
    endtask

    task automatic drive_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'd0; haddr[d] = 32'h0; hsize[d] = 3'd0;
        hwrite[d] = 1'b0; hexcl[d] = 1'b0; hmaster[d] = 4'd0;
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        hsel[d]    = x.gap ? x.gap_sel : 1'b1;
        htrans[d]  = x.trans;
        haddr[d]   = x.addr;
        hsize[d]   = 3'(x.size);
        hwrite[d]  = x.wr;
        hexcl[d]   = x.excl;
        hmaster[d] = 4'(x.mst);
    endtask

    // Final data-phase cycle: compare response with the model, then apply the
    // transfer to the model in program order.
    task automatic finish_xfer(input int d, input xfer_t x, input int waits);
        bit        err;
        bit        exp_ok;
        bit [31:0] exp_rd;
        bit [31:0] w;
        int        idx;
        int        lane;
        err    = !is_legal(x);
        exp_ok = 1'b0;
        exp_rd = 32'h0;
        idx    = int'(x.addr / 4);
        if (!err) begin
            if (!x.wr) exp_rd = mem_m[d][idx];
            else if (x.excl) exp_ok = rv[d] && (ridx[d] == idx) && (rmst[d] == x.mst);
        end
        check("resp", hresp[d], err);
        check("waits", waits, err ? 1 : ws_of(d));
        check("rdata", hrdata[d], exp_rd);
        check("hexokay", hexokay[d], exp_ok);
        if (!err) begin
            if (x.wr) begin
                if (!x.excl || exp_ok) begin
                    w = mem_m[d][idx];
                    for (int b = 0; b < (1 << x.size); b++) begin
                        lane = int'(x.addr % 4) + b;
                        w[8*lane +: 8] = x.wdata[8*lane +: 8];
                    end
                    mem_m[d][idx] = w;
                    if (rv[d] && ridx[d] == idx) rv[d] = 1'b0;
                end
            end else if (x.excl) begin
                rv[d] = 1'b1; ridx[d] = idx; rmst[d] = x.mst;
            end
        end
    endtask

    // Pipelined master: runs the queue to completion on slave d.
    // Entered and left just after a rising edge.
    task automatic run_q(input int d);
        xfer_t cur;
        xfer_t nx;
        bit    cur_v;
        bit    rdy;
        int    waits;
        int    cyc;
        cur_v = 1'b0; waits = 0; cyc = 0;
        while (cur_v || txq.size() != 0) begin
            if (txq.size() != 0) drive_addr(d, txq[0]);
            else drive_idle(d);
            hwdata[d] = (cur_v && cur.wr) ? cur.wdata : 32'h0;
            @(negedge hclk);
            rdy = hready[d];
            if (cur_v) begin
                if (!rdy) begin
                    waits++;
                    check("wait_resp", hresp[d], !is_legal(cur));
                    check("wait_rdata", hrdata[d], 0);
                end else begin
                    finish_xfer(d, cur, waits);
                    cur_v = 1'b0;
                end
            end else begin
                check("idle_rdy", rdy, 1);
                check("idle_resp", hresp[d], 0);
            end
            @(posedge hclk); #1;
            if (rdy && txq.size() != 0) begin
                nx = txq.pop_front();
                if (!nx.gap) begin
                    cur = nx; cur_v = 1'b1; waits = 0;
                end
            end
            cyc++;
            if (cyc > 4000) begin
                check("timeout", 1, 0);
                txq.delete();
                cur_v = 1'b0;
            end
        end
        drive_idle(d);
        hwdata[d] = 32'h0;
    endtask

    task automatic init_window(input int d);
        for (int i = 0; i < 64; i++) push_x(32'(i * 4), 2, 1'b1, 1'b0, 0, $urandom);
        run_q(d);
    endtask

    task automatic random_traffic(input int d, input int n);
        bit [31:0] a;
        int        sz;
        bit        ex;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                push_gap();
            end else begin
                sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                ex = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 19) == 0) a = 32'h1000 + ($urandom_range(0, 63) << 2);
                else if (ex) a = $urandom_range(0, 31);
                else a = $urandom_range(0, 255);
                if ($urandom_range(0, 5) != 0) a = a & ~((32'd1 << sz) - 1);
                push_x(a, sz, 1'($urandom_range(0, 1)), ex, int'($urandom_range(0, 2)), $urandom);
            end
        end
        run_q(d);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hburst = 3'd1; hmastlock = 1'b0; hprot = 7'h03; hnonsec = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            hresetn[d] = 1'b0; hwdata[d] = 32'h0; rv[d] = 1'b0; ridx[d] = 0; rmst[d] = 0;
            drive_idle(d);
        end
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_hready", hready[d], 1);
            check("rst_hresp", hresp[d], 0);
            check("rst_hexokay", hexokay[d], 0);
            check("rst_hrdata", hrdata[d], 0);
        end
        hresetn[0] = 1'b1; hresetn[1] = 1'b1;
        @(posedge hclk); #1;

        // ---------------- zero-wait slave ----------------
        init_window(0);
        push_x(32'h10, 2, 1'b1, 1'b0, 0, 32'hDEADBEEF);
        push_x(32'h10, 2, 1'b0, 1'b0, 0, 32'h0);
        run_q(0);
        // exclusive pair, success
        push_x(32'h40, 2, 1'b0, 1'b1, 2, 32'h0);
        push_x(32'h40, 2, 1'b1, 1'b1, 2, 32'hCAFE0001);
        push_x(32'h40, 2, 1'b0, 1'b0, 2, 32'h0);
        // exclusive pair broken by another master's plain write
        push_x(32'h40, 2, 1'b0, 1'b1, 2, 32'h0);
        push_x(32'h40, 2, 1'b1, 1'b0, 3, 32'h33333333);
        push_x(32'h40, 2, 1'b1, 1'b1, 2, 32'hCAFE0002);
        push_x(32'h40, 2, 1'b0, 1'b0, 2, 32'h0);
        // write immediately followed by an exclusive read of the same word
        push_x(32'h44, 2, 1'b1, 1'b0, 1, 32'h44444444);
        push_x(32'h44, 2, 1'b0, 1'b1, 1, 32'h0);
        push_x(32'h44, 2, 1'b1, 1'b1, 1, 32'h55555555);
        push_x(32'h44, 2, 1'b0, 1'b0, 1, 32'h0);
        // illegal accesses, then a normal transfer
        push_x(32'h1000, 2, 1'b0, 1'b0, 0, 32'h0);
        push_x(32'h03, 1, 1'b1, 1'b0, 0, 32'hFFFFFFFF);
        push_x(32'h00, 2, 1'b0, 1'b0, 0, 32'h0);
        push_x(32'h02, 1, 1'b0, 1'b0, 0, 32'h0);
        run_q(0);
        random_traffic(0, 250);

        // ---------------- three-wait slave ----------------
        init_window(1);
        push_x(32'h20, 2, 1'b1, 1'b0, 0, 32'h11223344);
        push_x(32'h21, 0, 1'b1, 1'b0, 0, 32'h0000AA00);
        push_x(32'h20, 2, 1'b0, 1'b0, 0, 32'h0);
        push_x(32'h1000, 2, 1'b0, 1'b0, 0, 32'h0);
        push_x(32'h20, 2, 1'b0, 1'b0, 0, 32'h0);
        run_q(1);
        random_traffic(1, 150);

        // reset during the wait states of a write to 0x80
        hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h80; hsize[1] = 3'd2;
        hwrite[1] = 1'b1; hexcl[1] = 1'b0; hmaster[1] = 4'd0;
        @(posedge hclk); #1;
        drive_idle(1);
        hwdata[1] = 32'h5A5A5A5A;
        @(negedge hclk);
        check("rst_mid_wait", hready[1], 0);
        @(posedge hclk); #1;
        hresetn[1] = 1'b0;
        @(posedge hclk); #1;
        @(negedge hclk);
        check("rst_mid_hready", hready[1], 1);
        check("rst_mid_hresp", hresp[1], 0);
        check("rst_mid_hexokay", hexokay[1], 0);
        check("rst_mid_hrdata", hrdata[1], 0);
        hresetn[1] = 1'b1;
        rv[1] = 1'b0;
        @(posedge hclk); #1;
        push_x(32'h80, 2, 1'b0, 1'b0, 0, 32'h0);
        run_q(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
